// File: rtl/length_counter_bank.sv
// rtl/length_counter_bank.sv - bank of table-loaded length counters with enable, halt and half-frame decrement
module length_counter_bank #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8
) (
  input  logic                    CLK,
  input  logic                    RES,
  input  logic                    LD_STB,
  input  logic [2:0]              LD_CH,
  input  logic [4:0]              LD_IDX,
  input  logic                    EN_STB,
  input  logic [NUM_CH-1:0]       EN_DATA,
  input  logic                    HF_STB,
  input  logic [NUM_CH-1:0]       HALT,
  output logic [NUM_CH*CNT_W-1:0] CNT,
  output logic [NUM_CH-1:0]       NZ
);

  logic [NUM_CH-1:0] en;
  logic [CNT_W-1:0]  cnt [NUM_CH];

  function automatic logic [7:0] len_lut(input logic [4:0] idx);
    case (idx)
      5'd0:  len_lut = 8'd10;   5'd1:  len_lut = 8'd254;
      5'd2:  len_lut = 8'd20;   5'd3:  len_lut = 8'd2;
      5'd4:  len_lut = 8'd40;   5'd5:  len_lut = 8'd4;
      5'd6:  len_lut = 8'd80;   5'd7:  len_lut = 8'd6;
      5'd8:  len_lut = 8'd160;  5'd9:  len_lut = 8'd8;
      5'd10: len_lut = 8'd60;   5'd11: len_lut = 8'd10;
      5'd12: len_lut = 8'd14;   5'd13: len_lut = 8'd12;
      5'd14: len_lut = 8'd26;   5'd15: len_lut = 8'd14;
      5'd16: len_lut = 8'd12;   5'd17: len_lut = 8'd16;
      5'd18: len_lut = 8'd24;   5'd19: len_lut = 8'd18;
      5'd20: len_lut = 8'd48;   5'd21: len_lut = 8'd20;
      5'd22: len_lut = 8'd96;   5'd23: len_lut = 8'd22;
      5'd24: len_lut = 8'd192;  5'd25: len_lut = 8'd24;
      5'd26: len_lut = 8'd72;   5'd27: len_lut = 8'd26;
      5'd28: len_lut = 8'd16;   5'd29: len_lut = 8'd28;
      5'd30: len_lut = 8'd32;   default: len_lut = 8'd30;
    endcase
  endfunction

  // The full 3-bit channel index is compared, so out-of-range indices never alias onto a real channel.
  always_ff @(posedge CLK) begin
    if (RES) begin
      en <= '0;
      for (int n = 0; n < NUM_CH; n++) cnt[n] <= '0;
    end else begin
      if (EN_STB) en <= EN_DATA;
      for (int n = 0; n < NUM_CH; n++) begin
        if (EN_STB && !EN_DATA[n])
          cnt[n] <= '0;
        else if (LD_STB && (LD_CH == 3'(n)) && en[n])
          cnt[n] <= CNT_W'(len_lut(LD_IDX));
        else if (HF_STB && !HALT[n] && (cnt[n] != '0))
          cnt[n] <= cnt[n] - CNT_W'(1);
      end
    end
  end

  always_comb begin
    CNT = '0;
    NZ  = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      CNT[n*CNT_W +: CNT_W] = cnt[n];
      NZ[n]                 = |cnt[n];
    end
  end

endmodule
